// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: access-size encodings, memory-stage FSM states,
// register-file write bundle width and store lane helpers.
package pipe_pkg;

    localparam int RF_ZIP_W = 6;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    function automatic logic [3:0] size_wstrb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            SZ_BYTE: strb = 4'b0001 << off;
            SZ_HALF: strb = 4'b0011 << {off[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target.
    function automatic logic [31:0] size_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wdata;
        case (size)
            SZ_BYTE: wdata = {4{data[7:0]}};
            SZ_HALF: wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data extraction: selects the addressed byte/half of a read word and
// sign- or zero-extends it to 32 bits.
module mem_load_ext
    import pipe_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension.
    always_comb begin
        case (addr_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        if (addr_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (size_i)
            SZ_BYTE: data_o = {{24{~is_unsigned_i & byte_s[7]}}, byte_s};
            SZ_HALF: data_o = {{16{~is_unsigned_i & half_s[15]}}, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one data-SRAM transaction per instruction, load extension,
// result hand-off to write-back. Optional decode bypass ports under MEM_FWD_EN.
module mem_stage
    import pipe_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                exe_to_mem_valid,
    output logic                mem_allowin,
    input  logic [31:0]         exe_pc,
    input  logic [31:0]         exe_alu_result,
    input  logic                exe_res_from_mem,
    input  logic                exe_mem_we,
    input  logic [1:0]          exe_mem_size,
    input  logic                exe_mem_unsigned,
    input  logic [31:0]         exe_rkd_value,
    input  logic [RF_ZIP_W-1:0] exe_rf_zip,
    input  logic                wb_allowin,
    output logic                mem_to_wb_valid,
    output logic [31:0]         mem_pc,
    output logic [31:0]         mem_final_result,
    output logic [RF_ZIP_W-1:0] mem_rf_zip,
`ifdef MEM_FWD_EN
    output logic                mem_fwd_valid,
    output logic [31:0]         mem_fwd_data,
`endif
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [1:0]          data_sram_size,
    output logic [3:0]          data_sram_wstrb,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata,
    input  logic                data_sram_addr_ok,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata
);

    mem_state_e          state_q, state_d;
    logic                mem_valid_q;
    logic [31:0]         pc_q;
    logic [31:0]         alu_result_q;
    logic                res_from_mem_q;
    logic                mem_we_q;
    logic [1:0]          mem_size_q;
    logic                mem_unsigned_q;
    logic [31:0]         rkd_value_q;
    logic [RF_ZIP_W-1:0] rf_zip_q;
    logic [31:0]         rdata_q;

    logic                mem_ready_go_s;
    logic                accept_s;
    logic                exe_is_mem_s;
    logic [31:0]         load_data_s;

    assign mem_ready_go_s = (state_q == ST_DONE);
    assign mem_allowin    = ~mem_valid_q | (mem_ready_go_s & wb_allowin);
    assign accept_s       = exe_to_mem_valid & mem_allowin;
    assign exe_is_mem_s   = exe_res_from_mem | exe_mem_we;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: REQ is left only on addr_ok, WAIT only on data_ok, so the request fires once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = exe_is_mem_s ? ST_REQ : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (data_sram_addr_ok) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (data_sram_data_ok) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (wb_allowin) begin
                    if (accept_s) begin
                        state_d = exe_is_mem_s ? ST_REQ : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage register and captured read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q    <= 1'b0;
            pc_q           <= 32'h0000_0000;
            alu_result_q   <= 32'h0000_0000;
            res_from_mem_q <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_size_q     <= 2'd0;
            mem_unsigned_q <= 1'b0;
            rkd_value_q    <= 32'h0000_0000;
            rf_zip_q       <= '0;
            rdata_q        <= 32'h0000_0000;
        end else begin
            if (mem_allowin) begin
                mem_valid_q <= exe_to_mem_valid;
            end
            if (accept_s) begin
                pc_q           <= exe_pc;
                alu_result_q   <= exe_alu_result;
                res_from_mem_q <= exe_res_from_mem;
                mem_we_q       <= exe_mem_we;
                mem_size_q     <= exe_mem_size;
                mem_unsigned_q <= exe_mem_unsigned;
                rkd_value_q    <= exe_rkd_value;
                rf_zip_q       <= exe_rf_zip;
            end
            if ((state_q == ST_WAIT) && data_sram_data_ok) begin
                rdata_q <= data_sram_rdata;
            end
        end
    end

    mem_load_ext u_load_ext (
        .rdata_i       (rdata_q),
        .addr_i        (alu_result_q[1:0]),
        .size_i        (mem_size_q),
        .is_unsigned_i (mem_unsigned_q),
        .data_o        (load_data_s)
    );

    assign data_sram_req   = (state_q == ST_REQ);
    assign data_sram_wr    = mem_we_q;
    assign data_sram_size  = mem_size_q;
    assign data_sram_addr  = alu_result_q;
    assign data_sram_wstrb = mem_we_q ? size_wstrb(mem_size_q, alu_result_q[1:0]) : 4'b0000;
    assign data_sram_wdata = size_wdata(mem_size_q, rkd_value_q);

    assign mem_to_wb_valid  = mem_valid_q & mem_ready_go_s;
    assign mem_pc           = pc_q;
    assign mem_final_result = res_from_mem_q ? load_data_s : alu_result_q;
    assign mem_rf_zip       = {rf_zip_q[RF_ZIP_W-1] & mem_valid_q, rf_zip_q[RF_ZIP_W-2:0]};

`ifdef MEM_FWD_EN
    assign mem_fwd_valid = mem_valid_q & rf_zip_q[RF_ZIP_W-1] & mem_ready_go_s;
    assign mem_fwd_data  = mem_final_result;
`else
    // Without bypass, decode stalls on a mem_rf_zip match.
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random instruction stream, SRAM responder with
// random latencies, byte-level reference memory model.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        exe_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] exe_pc, exe_alu_result, exe_rkd_value;
    logic        exe_res_from_mem, exe_mem_we, exe_mem_unsigned;
    logic [1:0]  exe_mem_size;
    logic [5:0]  exe_rf_zip;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [31:0] mem_pc, mem_final_result;
    logic [5:0]  mem_rf_zip;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    mem_stage dut (
        .clk(clk), .resetn(resetn),
        .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin),
        .exe_pc(exe_pc), .exe_alu_result(exe_alu_result),
        .exe_res_from_mem(exe_res_from_mem), .exe_mem_we(exe_mem_we),
        .exe_mem_size(exe_mem_size), .exe_mem_unsigned(exe_mem_unsigned),
        .exe_rkd_value(exe_rkd_value), .exe_rf_zip(exe_rf_zip),
        .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid),
        .mem_pc(mem_pc), .mem_final_result(mem_final_result), .mem_rf_zip(mem_rf_zip),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] res; logic [5:0] zip; } exp_t;
    typedef struct { logic wr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] addr; logic [31:0] wdata; } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem [16];
    int          errors = 0;
    int          checks = 0;
    int          hold_addr_ok = 0;
    bit          block_data_ok = 1'b0;
    bit          inject_data_ok = 1'b0;
    bit          pending = 1'b0;
    logic [3:0]  p_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Reference load: gather the addressed bytes, then extend by hand.
    function automatic logic [31:0] ld_model(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] sz, input bit uns);
        int n = nbytes(sz);
        logic [31:0] v = 32'h0;
        for (int b = 0; b < n; b++) v[8*b +: 8] = word[8*(off+b) +: 8];
        if (!uns && n < 4 && v[8*n-1]) for (int b = n; b < 4; b++) v[8*b +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic cyc(input bit wb);
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        wb_allowin = wb;
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] alu, input bit ld, input bit st,
                        input logic [1:0] sz, input bit uns, input logic [31:0] rkd,
                        input logic [5:0] zip, input bit rand_wb, input bit ovr,
                        input logic [31:0] ovr_res);
        int budget = 100;
        bit acc = 1'b0;
        exp_t e;
        req_t r;
        int n = nbytes(sz);
        logic [1:0] off = alu[1:0];
        logic [3:0] idx = alu[5:2];
        while (!acc && budget > 0) begin
            @(negedge clk);
            exe_to_mem_valid = 1'b1;
            exe_pc = pc; exe_alu_result = alu; exe_res_from_mem = ld; exe_mem_we = st;
            exe_mem_size = sz; exe_mem_unsigned = uns; exe_rkd_value = rkd; exe_rf_zip = zip;
            wb_allowin = rand_wb ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (mem_allowin) acc = 1'b1;
            budget--;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: pc %h never accepted", pc);
            return;
        end
        e.pc = pc; e.zip = zip; e.res = alu;
        if (ld) e.res = ld_model(ref_mem[idx], off, sz, uns);
        if (st) for (int b = 0; b < n; b++) ref_mem[idx][8*(off+b) +: 8] = rkd[8*b +: 8];
        if (ovr) e.res = ovr_res;
        exp_q.push_back(e);
        if (ld || st) begin
            r.wr = st; r.size = sz; r.addr = alu; r.wstrb = 4'b0000;
            if (st) for (int b = 0; b < n; b++) r.wstrb[off+b] = 1'b1;
            for (int l = 0; l < 4; l++) r.wdata[8*l +: 8] = rkd[8*(l % n) +: 8];
            req_q.push_back(r);
        end
    endtask

    task automatic drain();
        int b = 0;
        while ((exp_q.size() != 0 || mem_to_wb_valid) && b < 300) begin
            cyc(1'b1);
            b++;
        end
        if (b >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
        end
    endtask

    // Write-back monitor: compare each result as it transfers.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (resetn && mem_to_wb_valid && wb_allowin) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: pc %h result %h", mem_pc, mem_final_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_pc", mem_pc, e.pc);
                    chk("wb_result", mem_final_result, e.res);
                    chk("wb_rf_zip", {26'h0, mem_rf_zip}, {26'h0, e.zip});
                end
            end
        end
    end

    // SRAM responder: random addr_ok/data_ok, junk data_ok whenever nothing is outstanding.
    initial begin
        req_t r;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pending = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
            end else begin
                if (inject_data_ok) begin
                    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
                end else if (pending && !block_data_ok && $urandom_range(0, 2) == 0) begin
                    data_sram_data_ok = 1'b1; data_sram_rdata = slave_mem[p_idx]; pending = 1'b0;
                end else begin
                    data_sram_data_ok = pending ? 1'b0 : ($urandom_range(0, 3) == 0);
                    data_sram_rdata = $urandom;
                end
                data_sram_addr_ok = (hold_addr_ok > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
                if (hold_addr_ok > 0 && data_sram_req) hold_addr_ok--;
                #1;
                if (data_sram_req && data_sram_addr_ok) begin
                    if (req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected: addr %h", data_sram_addr);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_wr", {31'h0, data_sram_wr}, {31'h0, r.wr});
                        chk("req_size", {30'h0, data_sram_size}, {30'h0, r.size});
                        chk("req_wstrb", {28'h0, data_sram_wstrb}, {28'h0, r.wstrb});
                        chk("req_addr", data_sram_addr, r.addr);
                        chk("req_wdata", data_sram_wdata, r.wdata);
                    end
                    pending = 1'b1;
                    p_idx = data_sram_addr[5:2];
                    if (data_sram_wr)
                        for (int l = 0; l < 4; l++)
                            if (data_sram_wstrb[l]) slave_mem[p_idx][8*l +: 8] = data_sram_wdata[8*l +: 8];
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] alu;
        int          kind;
        bit          ld, st;
        resetn = 1'b0; exe_to_mem_valid = 1'b0; wb_allowin = 1'b1;
        exe_pc = 32'h0; exe_alu_result = 32'h0; exe_res_from_mem = 1'b0; exe_mem_we = 1'b0;
        exe_mem_size = 2'd0; exe_mem_unsigned = 1'b0; exe_rkd_value = 32'h0; exe_rf_zip = 6'h0;
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i] = slave_mem[i];
        end
        slave_mem[0] = 32'h80FF_7F01; ref_mem[0] = 32'h80FF_7F01;
        slave_mem[2] = 32'hCAFE_F00D; ref_mem[2] = 32'hCAFE_F00D;
        repeat (3) cyc(1'b1);
        resetn = 1'b1;
        #1;
        chk("rst_allowin", {31'h0, mem_allowin}, 32'h1);
        chk("rst_wb_valid", {31'h0, mem_to_wb_valid}, 32'h0);
        chk("rst_req", {31'h0, data_sram_req}, 32'h0);
        chk("rst_pc", mem_pc, 32'h0);
        chk("rst_result", mem_final_result, 32'h0);
        chk("rst_rf_zip", {26'h0, mem_rf_zip}, 32'h0);
        chk("rst_wr_wstrb", {27'h0, data_sram_wr, data_sram_wstrb}, 32'h0);
        chk("rst_addr", data_sram_addr, 32'h0);
        chk("rst_wdata", data_sram_wdata, 32'h0);

        // Non-memory op: result and rf_zip visible in the accept cycle, no request.
        send(32'h100, 32'h1234_5678, 0, 0, 2'd2, 0, 32'h0, 6'h23, 0, 1, 32'h1234_5678);
        cyc(1'b1);
        chk("nonmem_valid", {31'h0, mem_to_wb_valid}, 32'h1);
        chk("nonmem_result", mem_final_result, 32'h1234_5678);
        chk("nonmem_rf_zip", {26'h0, mem_rf_zip}, 32'h23);
        chk("nonmem_req", {31'h0, data_sram_req}, 32'h0);
        drain();

        send(32'h104, 32'h1003, 1, 0, 2'd0, 0, 32'h0, 6'h24, 0, 1, 32'hFFFF_FF80);
        send(32'h108, 32'h1003, 1, 0, 2'd0, 1, 32'h0, 6'h25, 0, 1, 32'h0000_0080);
        send(32'h10C, 32'h2002, 0, 1, 2'd1, 0, 32'h0000_ABCD, 6'h07, 0, 0, 32'h0);
        cyc(1'b1);
        chk("sth_req", {31'h0, data_sram_req}, 32'h1);
        chk("sth_wr_size", {29'h0, data_sram_wr, data_sram_size}, 32'h5);
        chk("sth_wstrb", {28'h0, data_sram_wstrb}, 32'hC);
        chk("sth_wdata", data_sram_wdata, 32'hABCD_ABCD);
        drain();

        // addr_ok withheld for three request cycles.
        hold_addr_ok = 3;
        send(32'h200, 32'h3004, 1, 0, 2'd2, 0, 32'h0, 6'h21, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            chk("hold_req", {31'h0, data_sram_req}, 32'h1);
            chk("hold_addr", data_sram_addr, 32'h3004);
            chk("hold_allowin", {31'h0, mem_allowin}, 32'h0);
        end
        drain();

        // Write-back back-pressure while DONE.
        send(32'h300, 32'h1008, 1, 0, 2'd2, 0, 32'h0, 6'h22, 0, 1, 32'hCAFE_F00D);
        for (int b = 0; b < 50 && !mem_to_wb_valid; b++) cyc(1'b0);
        chk("bp_reached_done", {31'h0, mem_to_wb_valid}, 32'h1);
        cyc(1'b0);
        chk("bp_valid_held", {31'h0, mem_to_wb_valid}, 32'h1);
        chk("bp_result_held", mem_final_result, 32'hCAFE_F00D);
        chk("bp_no_req", {31'h0, data_sram_req}, 32'h0);
        cyc(1'b1);
        chk("bp_release_valid", {31'h0, mem_to_wb_valid}, 32'h1);
        cyc(1'b1);
        chk("bp_drained", {31'h0, mem_to_wb_valid}, 32'h0);
        drain();

        // Reset while waiting for data_ok, then a stray data_ok.
        block_data_ok = 1'b1;
        send(32'h400, 32'h1010, 1, 0, 2'd2, 0, 32'h0, 6'h26, 0, 0, 32'h0);
        for (int b = 0; b < 50 && !pending; b++) cyc(1'b1);
        chk("rstw_in_wait", {31'h0, pending}, 32'h1);
        @(negedge clk);
        resetn = 1'b0; exe_to_mem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete(); req_q.delete(); block_data_ok = 1'b0;
        resetn = 1'b1;
        #1;
        chk("rstw_req", {31'h0, data_sram_req}, 32'h0);
        chk("rstw_wb_valid", {31'h0, mem_to_wb_valid}, 32'h0);
        chk("rstw_allowin", {31'h0, mem_allowin}, 32'h1);
        chk("rstw_pc", mem_pc, 32'h0);
        inject_data_ok = 1'b1;
        cyc(1'b1);
        inject_data_ok = 1'b0;
        cyc(1'b1);
        chk("stray_ok_req", {31'h0, data_sram_req}, 32'h0);
        chk("stray_ok_wb_valid", {31'h0, mem_to_wb_valid}, 32'h0);
        chk("stray_ok_allowin", {31'h0, mem_allowin}, 32'h1);
        chk("stray_ok_result", mem_final_result, 32'h0);

        // Random instruction stream.
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            ld = (kind < 4);
            st = (kind >= 4 && kind < 7);
            sz = 2'($urandom_range(0, (ld || st) ? 2 : 3));
            alu = $urandom;
            if (ld || st) begin
                if (sz == 2'd1) alu[0] = 1'b0;
                if (sz == 2'd2) alu[1:0] = 2'b00;
            end
            send($urandom, alu, ld, st, sz, 1'($urandom_range(0, 1)), $urandom,
                 {st ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))},
                 1, 0, 32'h0);
            if ($urandom_range(0, 3) == 0) cyc(1'($urandom_range(0, 1)));
        end
        drain();
        chk("all_reqs_issued", req_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
